debug_cmd_bridge: RTL

- Parametrised system-clock half of the on-chip debug slave.
- Receives update and capture toggles from the JTAG (tck) domain and synchronises them into clk.
- Captures the shifted data register with the instruction code active at that moment and queues each command in a FIFO.
- Presents commands to the debug core over a valid/ready handshake, with one-hot take-action pulses per instruction code. Unlike the previous fixed 2-bit/38-bit, unbuffered generation, IR width, DR width, synchroniser depth and queue depth are all parameters.

---
 rtl/debug_cmd_bridge.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/debug_cmd_bridge.sv
// debug_cmd_bridge
// System-clock half of the on-chip debug slave. Update (uir_tgl) and
// capture (e1dr_tgl) toggles arriving from the tck domain are synchronised
// into clk; each capture queues {instruction code, shifted data} in a
// first-word fall-through FIFO presented over a valid/ready handshake.
//
// Ports:
//   clk, reset_n   system clock, asynchronous active-low reset
//   uir_tgl        toggle, flips once per IR update (async)
//   e1dr_tgl       toggle, flips once per DR exit1 (async)
//   ir_in          instruction code from the tck domain
//   sr             shifted data register from the tck domain
//   cmd_valid      FIFO head valid
//   cmd_ready      consumer accepts the head
//   cmd_ir         head instruction code
//   cmd_data       head data
//   take_action    one-hot pulse on pop, bit index = cmd_ir
//   cur_ir         last synchronised instruction code
//   ir_update      one-cycle pulse when cur_ir loads
//   fill_level     entries held, 0..FIFO_DEPTH
//   overflow       sticky, a capture was dropped on a full FIFO
//   clr_overflow   synchronous clear of overflow (a new drop wins)
module debug_cmd_bridge #(
   parameter int unsigned IR_W        = 2,
   parameter int unsigned DR_W        = 38,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          uir_tgl,
   input  logic                          e1dr_tgl,
   input  logic [IR_W-1:0]               ir_in,
   input  logic [DR_W-1:0]               sr,
   output logic                          cmd_valid,
   input  logic                          cmd_ready,
   output logic [IR_W-1:0]               cmd_ir,
   output logic [DR_W-1:0]               cmd_data,
   output logic [2**IR_W-1:0]            take_action,
   output logic [IR_W-1:0]               cur_ir,
   output logic                          ir_update,
   output logic [$clog2(FIFO_DEPTH):0]   fill_level,
   output logic                          overflow,
   input  logic                          clr_overflow
);

   localparam int unsigned AW    = $clog2(FIFO_DEPTH);
   localparam int unsigned NA    = 2**IR_W;
   localparam int unsigned EW    = IR_W + DR_W;
   localparam int unsigned ARM_W = $clog2(SYNC_STAGES + 2);
   localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);
   localparam logic [AW:0]      FULL     = (AW+1)'(FIFO_DEPTH);

   logic [SYNC_STAGES-1:0] uir_sync;
   logic [SYNC_STAGES-1:0] e1dr_sync;
   logic                   uir_edge;
   logic                   e1dr_edge;
   logic                   uir_evt;
   logic                   e1dr_evt;
   logic [ARM_W-1:0]       arm_cnt;
   logic                   armed;
   logic                   uir_raw;
   logic                   e1dr_raw;

   logic [EW-1:0]          mem [FIFO_DEPTH];
   logic [AW-1:0]          wptr;
   logic [AW-1:0]          rptr;
   logic [EW-1:0]          head;
   logic [IR_W-1:0]        ir_sel;
   logic                   pop;
   logic                   full;
   logic                   accept;
   logic                   drop;

   assign armed    = (arm_cnt == ARM_DONE);
   // Edge registers always follow the synchronised value; only the event is
   // gated, so a toggle left high across reset is absorbed during arming.
   assign uir_raw  = armed & (uir_sync[SYNC_STAGES-1]  ^ uir_edge);
   assign e1dr_raw = armed & (e1dr_sync[SYNC_STAGES-1] ^ e1dr_edge);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         uir_sync  <= '0;
         e1dr_sync <= '0;
         uir_edge  <= 1'b0;
         e1dr_edge <= 1'b0;
         uir_evt   <= 1'b0;
         e1dr_evt  <= 1'b0;
         arm_cnt   <= '0;
      end else begin
         uir_sync  <= {uir_sync[SYNC_STAGES-2:0], uir_tgl};
         e1dr_sync <= {e1dr_sync[SYNC_STAGES-2:0], e1dr_tgl};
         uir_edge  <= uir_sync[SYNC_STAGES-1];
         e1dr_edge <= e1dr_sync[SYNC_STAGES-1];
         uir_evt   <= uir_raw;
         e1dr_evt  <= e1dr_raw;
         if (!armed) arm_cnt <= arm_cnt + ARM_W'(1);
      end
   end

   // A capture coinciding with an IR update takes the fresh code directly.
   assign ir_sel = uir_evt ? ir_in : cur_ir;
   assign pop    = cmd_valid & cmd_ready;
   assign full   = (fill_level == FULL);
   assign accept = e1dr_evt & (~full | pop);
   assign drop   = e1dr_evt & full & ~pop;

   always_ff @(posedge clk) begin
      if (accept) mem[wptr] <= {ir_sel, sr};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr       <= '0;
         rptr       <= '0;
         fill_level <= '0;
         overflow   <= 1'b0;
         cur_ir     <= '0;
         ir_update  <= 1'b0;
      end else begin
         if (accept) wptr <= wptr + AW'(1);
         if (pop)    rptr <= rptr + AW'(1);
         unique case ({accept, pop})
            2'b10:   fill_level <= fill_level + (AW+1)'(1);
            2'b01:   fill_level <= fill_level - (AW+1)'(1);
            default: fill_level <= fill_level;
         endcase
         overflow  <= drop | (overflow & ~clr_overflow);
         ir_update <= uir_evt;
         if (uir_evt) cur_ir <= ir_in;
      end
   end

   assign head = mem[rptr];

   always_comb begin
      cmd_valid   = (fill_level != '0);
      cmd_ir      = '0;
      cmd_data    = '0;
      take_action = '0;
      if (cmd_valid) begin
         cmd_ir   = head[EW-1:DR_W];
         cmd_data = head[DR_W-1:0];
      end
      if (pop) take_action = NA'(1) << cmd_ir;
   end

endmodule
